// File: rtl/lpddr3_dm_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lpddr3_dm_delay_line_ctrl
// Purpose  : Sequences load / move-N-taps commands onto the dynamic delay
//            line of one LPDDR3 DM lane IOD and tracks the tap position.
// Revision : 1.0 - initial release
// ============================================================================
module lpddr3_dm_delay_line_ctrl #(
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 127,
    parameter int INIT_TAP      = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOAD_CYCLES   = 2
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_STEPS,
    output logic             DONE,
    output logic             ERR,
    output logic             BUSY,
    output logic [TAP_W-1:0] TAP_COUNT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int               c_CNT_W       = 4;
    localparam logic [TAP_W-1:0] c_MAX_TAP     = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] c_INIT_TAP    = TAP_W'(INIT_TAP);
    localparam logic [c_CNT_W-1:0] c_LOAD_LAST   = c_CNT_W'(LOAD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_INC  = 2'b01;
    localparam logic [1:0] c_OP_DEC  = 2'b10;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_DIR_SETUP = 3'd2;
    localparam logic [2:0] S_MOVE      = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [TAP_W-1:0]   r_steps;
    logic [TAP_W-1:0]   r_tap;
    logic               r_dir;
    logic               r_load;
    logic               r_move;
    logic               r_done;
    logic               r_err;
    logic               r_busy;
    logic               r_ready;

    logic               w_accept;
    logic [TAP_W-1:0]   w_tap_nxt;
    logic               w_blocked_now;
    logic               w_blocked_nxt;

    assign w_accept  = CMD_VALID && r_ready;
    assign w_tap_nxt = r_dir ? (r_tap + 1'b1) : (r_tap - 1'b1);

    // Limit check before a pulse: current tap on the first step, the tap
    // being committed this cycle on subsequent steps.
    assign w_blocked_now = r_dir ? (r_tap >= c_MAX_TAP)     : (r_tap == '0);
    assign w_blocked_nxt = r_dir ? (w_tap_nxt >= c_MAX_TAP) : (w_tap_nxt == '0);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_steps <= '0;
            r_tap   <= c_INIT_TAP;
            r_dir   <= 1'b0;
            r_load  <= 1'b0;
            r_move  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_move <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_steps <= CMD_STEPS;
                        if (CMD_OP == c_OP_LOAD) begin
                            r_state <= S_LOAD;
                            r_load  <= 1'b1;
                            r_cnt   <= c_LOAD_LAST;
                        end else if ((CMD_OP == c_OP_INC) || (CMD_OP == c_OP_DEC)) begin
                            if (CMD_STEPS == '0) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_DIR_SETUP;
                                r_dir   <= (CMD_OP == c_OP_INC);
                            end
                        end else begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_cnt == '0) begin
                        r_load  <= 1'b0;
                        r_tap   <= c_INIT_TAP;
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIR_SETUP: begin
                    if (w_blocked_now) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_MOVE;
                        r_move  <= 1'b1;
                    end
                end
                S_MOVE: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= c_SETTLE_LAST;
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (DELAY_LINE_OUT_OF_RANGE) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_tap   <= w_tap_nxt;
                        r_steps <= r_steps - 1'b1;
                        if (r_steps == TAP_W'(1)) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else if (w_blocked_nxt) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_MOVE;
                            r_move  <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign CMD_READY            = r_ready;
    assign DONE                 = r_done;
    assign ERR                  = r_err;
    assign BUSY                 = r_busy;
    assign TAP_COUNT            = r_tap;
    assign DELAY_LINE_LOAD      = r_load;
    assign DELAY_LINE_MOVE      = r_move;
    assign DELAY_LINE_DIRECTION = r_dir;

endmodule
`default_nettype wire

// File: doc/lpddr3_dm_delay_line_ctrl.md
Name: lpddr3_dm_delay_line_ctrl

Overview:
Sequencer for the dynamic delay line of one LPDDR3 DM lane IOD. It accepts load and move-N-taps commands from the training logic over a valid/ready handshake. It drives the IOD's DELAY_LINE_LOAD, DELAY_LINE_MOVE and DELAY_LINE_DIRECTION with legal spacing, tracks the current tap position, and reports range violations. It sits between the PHY training FSM and the lane IOD wrapper, in the FAB_CLK domain.

Parameters:
TAP_W, 8, width of tap counter and step count
MAX_TAP, 127, highest legal tap index
INIT_TAP, 1, tap value after a load (matches static TX delay value)
SETTLE_CYCLES, 4, wait cycles after each move pulse before the next action (range 1..15)
LOAD_CYCLES, 2, cycles DELAY_LINE_LOAD is held high (range 1..7)

Ports:
FAB_CLK  in  1  fabric clock; all logic rising-edge
ARST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  controller can accept a command
CMD_OP  in  2  00 load, 01 move increment, 10 move decrement, 11 reserved
CMD_STEPS  in  TAP_W  number of taps to move (ignored for load)
DONE  out  1  one-cycle pulse on command completion
ERR  out  1  one-cycle pulse coincident with DONE when the command terminated abnormally
BUSY  out  1  high while a command is in progress, including the DONE cycle
TAP_COUNT  out  TAP_W  current tracked tap position
DELAY_LINE_LOAD  out  1  to IOD
DELAY_LINE_MOVE  out  1  to IOD, one-cycle pulse per tap
DELAY_LINE_DIRECTION  out  1  to IOD, 1 = increment
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD, synchronous to FAB_CLK

Behaviour:
- Reset (async assert, sync release): state IDLE. CMD_READY=1. DONE=ERR=BUSY=0. TAP_COUNT=INIT_TAP. LOAD=MOVE=DIRECTION=0. Reset mid-command aborts immediately; no DONE is issued.
- Handshake: a command is accepted when CMD_VALID&&CMD_READY (cycle t). CMD_OP and CMD_STEPS are captured at t. CMD_READY=1 only in IDLE. All outputs are registered.
- States: IDLE, LOAD, DIR_SETUP, CHECK, MOVE, SETTLE, FINISH.
- Load (00): LOAD is high for cycles t+1 .. t+LOAD_CYCLES. FINISH is at t+LOAD_CYCLES+1 with DONE=1. TAP_COUNT becomes INIT_TAP in the FINISH cycle. OUT_OF_RANGE is ignored.
- Move (01/10): DIR_SETUP at t+1 drives DIRECTION. DIRECTION holds until the next move command; it is not changed by load.
- CHECK (combinational, same cycle as entry to MOVE) tests the limits. An inc with TAP_COUNT==MAX_TAP, or a dec with TAP_COUNT==0, goes to FINISH with ERR=1 and no pulse.
- MOVE: MOVE=1 for exactly one cycle.
- SETTLE: lasts SETTLE_CYCLES cycles. In the last SETTLE cycle, OUT_OF_RANGE is sampled.
  - If OUT_OF_RANGE=1: TAP_COUNT is unchanged, and the next state is FINISH with ERR=1.
  - Otherwise: TAP_COUNT is incremented or decremented by 1, and the remaining step count is decremented.
  - Next state is MOVE if steps remain, else FINISH.
- Move timing with no error: the first MOVE pulse is at t+2, and pulses are spaced 1+SETTLE_CYCLES apart. DONE is at t+2+N*(1+SETTLE_CYCLES).
- CMD_STEPS=0: FINISH at t+1, DONE=1, ERR=0, no pulses, DIRECTION not updated.
- Reserved op (11): FINISH at t+1 with DONE=1, ERR=1, no IOD activity.
- FINISH lasts one cycle, then returns to IDLE; CMD_READY rises the following cycle. A back-to-back command is accepted at the earliest one cycle after DONE.
- MOVE and LOAD are never high in the same cycle. MOVE never pulses in the DIR_SETUP cycle.
- TAP_COUNT never exceeds MAX_TAP and never wraps below 0.

Test Plan:
- Reset then load: ARST_N released, CMD_OP=00 accepted at t (LOAD_CYCLES=2) -> LOAD high t+1,t+2; DONE t+3, ERR=0; TAP_COUNT=1.
- Move +3 from tap 1 (SETTLE=4): accept at t -> DIRECTION=1 at t+1; MOVE pulses at t+2, t+7, t+12; DONE at t+17; TAP_COUNT=4.
- Decrement at floor: TAP_COUNT=0, move -1 -> no MOVE pulse; DONE+ERR at t+2; TAP_COUNT=0. Likewise, inc at 127 -> ERR, TAP_COUNT=127.
- Out-of-range abort: move +5 from 10, OUT_OF_RANGE forced high from the 3rd pulse -> exactly 3 MOVE pulses; DONE+ERR 5 cycles after the 3rd pulse; TAP_COUNT=12.
- Zero steps / reserved op: CMD_STEPS=0 -> DONE at t+1, ERR=0. CMD_OP=11 -> DONE+ERR at t+1. No LOAD/MOVE activity in either case.
- Reset mid-move: assert ARST_N low during SETTLE of the 2nd step -> all outputs at reset values immediately; TAP_COUNT=INIT_TAP; no DONE after release; next command accepted normally.
